// File: rtl/rvm_mem_responder_if.sv
// rtl/rvm_mem_responder_if.sv - rvm_core memory bus bundle between core (master) and responder (slave)
//
// Purpose: groups the request/response signals of the rvm_core mem_* port.
// Signals:
//   mem_c_en   master->slave  access request, held high until completion
//   mem_w_en   master->slave  1 = write, 0 = read
//   mem_b_en   master->slave  byte enables, bit n covers wdata[8n+7:8n]
//   mem_addr   master->slave  byte address
//   mem_wdata  master->slave  write data
//   mem_rdata  slave->master  read data, valid in the response cycle only
//   mem_stall  slave->master  request pending and not yet complete
//   mem_error  slave->master  illegal access, response cycle only
interface rvm_mem_responder_if;
  logic        mem_c_en;
  logic        mem_w_en;
  logic [3:0]  mem_b_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_error;

  modport master (
    output mem_c_en, mem_w_en, mem_b_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_stall, mem_error
  );

  modport slave (
    input  mem_c_en, mem_w_en, mem_b_en, mem_addr, mem_wdata,
    output mem_rdata, mem_stall, mem_error
  );
endinterface

// File: rtl/rvm_mem_responder.sv
// rtl/rvm_mem_responder.sv - single-outstanding memory responder with wait states and error signalling
//
// Purpose: services one read/write at a time from an internal word RAM.
// Each access goes IDLE -> (WAIT x N) -> RESP -> IDLE; RESP is the only
// cycle with stall low while the request is held.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    rvm_mem_responder_if.slave (mem_* request/response signals)
// Optional feature macro: RVM_MEM_RESP_RANDSTALL_EN adds 0..3 pseudo-random
// extra wait cycles per access from a 16-bit Fibonacci LFSR.
module rvm_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  rvm_mem_responder_if.slave   bus
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q;
  logic            error_q;

  // Request attributes latched when the access leaves IDLE.
  logic            wen_q;
  logic [3:0]      ben_q;
  logic [31:0]     wdata_q;
  logic [IW-1:0]   idx_q;
  logic            legal_q;

  logic [31:0]     ram_q [DEPTH_WORDS];

  logic            capture;
  logic            enter_resp;
  logic            commit;
  logic [4:0]      load_cnt;

  // Address decode from the live bus; only used on the edge leaving IDLE.
  logic [31:0]     off;
  logic            dec_legal;
  logic [IW-1:0]   dec_idx;

  assign off       = bus.mem_addr - ADDR_BASE;
  assign dec_legal = (bus.mem_addr >= ADDR_BASE) &&
                     ((off >> 2) < 32'(DEPTH_WORDS)) &&
                     (bus.mem_addr[1:0] == 2'b00);
  assign dec_idx   = off[IW+1:2];

`ifdef RVM_MEM_RESP_RANDSTALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Taps 16,14,13,11 in right-shifting form.
  assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign load_cnt = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  assign load_cnt = 5'(WAIT_STATES);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_c_en) begin
          capture = 1'b1;
          if (load_cnt == 5'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = load_cnt;
          end
        end
      end
      S_WAIT: begin
        if (!bus.mem_c_en) begin
          // Abort: the master gave up, drop the access silently.
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end else if (cnt_q == 5'd1) begin
          state_d    = S_RESP;
          cnt_d      = 5'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        commit  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // With zero wait the access enters RESP on the same edge it leaves IDLE,
  // so the read path must use the live decode instead of the latched one.
  logic          legal_sel;
  logic          wen_sel;
  logic [IW-1:0] idx_sel;

  assign legal_sel = capture ? dec_legal       : legal_q;
  assign wen_sel   = capture ? bus.mem_w_en    : wen_q;
  assign idx_sel   = capture ? dec_idx         : idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rdata_q <= (legal_sel && !wen_sel) ? ram_q[idx_sel] : 32'd0;
        error_q <= !legal_sel;
      end else if (state_q == S_RESP) begin
        rdata_q <= 32'd0;
        error_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      wen_q   <= bus.mem_w_en;
      ben_q   <= bus.mem_b_en;
      wdata_q <= bus.mem_wdata;
      idx_q   <= dec_idx;
      legal_q <= dec_legal;
    end
  end

  // Write commits on the edge leaving RESP; reset drops a pending write.
  always_ff @(posedge clk) begin
    if (!reset && commit && wen_q && legal_q) begin
      for (int b = 0; b < 4; b++) begin
        if (ben_q[b]) begin
          ram_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_stall = !reset && bus.mem_c_en && (state_q != S_RESP);
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_error = error_q;

endmodule
